aegis_result_streamer: RTL and testbench
========================================

Name: aegis_result_streamer

Overview:
- Downstream stage of the turbo multiply-accumulate engine.
- Snapshots the 128-bit accumulator when the engine signals completion. Streams it out as 16 bytes, then one XOR checksum byte, over a valid/ready byte interface.
- Replaces the fixed low-byte tap (acc[7:0]) so host logic can read the full hash through the 8-bit output pins.

Parameters:
- ACC_W, 128, accumulator width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, output byte width.
- LSB_FIRST, 1, 1 = byte 0 is acc[7:0]; 0 = byte 0 is acc[ACC_W-1 -: 8].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- acc_in  in  ACC_W  accumulator value from the MAC stage
- acc_done  in  1  single-cycle pulse: acc_in is final (MAC step counter reached 16)
- out_data  out  BYTE_W  current byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the byte this cycle
- out_first  out  1  high with byte 0 of a frame
- out_last  out  1  high with the checksum byte
- busy  out  1  frame in progress (state != IDLE)
- overrun  out  1  sticky: acc_done arrived while busy and was dropped
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, idx=0, snapshot=0, csum=0.
  - out_valid=0, out_first=0, out_last=0, out_data=0, busy=0, overrun=0.
- Handshake:
  - A byte transfers on a cycle with out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_first and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- FSM states:
  - IDLE: out_valid=0. When acc_done=1, capture acc_in into snapshot, idx=0, csum=0, go to STREAM. out_valid rises the next cycle, so latency is 1 clk from acc_done to the first valid byte.
  - STREAM: out_data = byte idx of snapshot, in the order set by LSB_FIRST. out_first = (idx==0). On a transfer: csum ^= out_data and idx++. On the transfer with idx==15, go to CSUM.
  - CSUM: out_data = csum (the XOR of all 16 bytes), out_last=1. On a transfer, go to IDLE.
- Simultaneous events:
  - acc_done in the same cycle as the CSUM transfer: capture and go directly to STREAM (back-to-back frames, no idle cycle, no overrun).
  - acc_done in STREAM, or in CSUM without a transfer: dropped; snapshot is not modified; overrun is set.
  - overrun_clr and a new overrun event in the same cycle: the set wins.
- idx is 4 bits. It wraps only via the CSUM→IDLE/STREAM path; it never wraps inside STREAM.
- acc_in is sampled only on the capture cycle. Changes to acc_in mid-frame have no effect.
- Reset asserted mid-frame aborts the frame immediately. Partial bytes are lost and no checksum is emitted.
- Frame length is fixed at 17 transfers. The minimum frame time is 17 cycles with out_ready held high.

Decomposition:
- Shared package aegis_pkg:
  - state encoding (IDLE=2'd0, STREAM=2'd1, CSUM=2'd2)
  - ACC_W / BYTE_W defaults
  - BYTES_PER_FRAME = ACC_W/BYTE_W
- One natural sub-module: aegis_byte_mux. Combinational snapshot+idx → byte select, honouring LSB_FIRST. It is reused by a future debug readback path.
- FSM, checksum and overrun logic stay in the top block.

Test Plan:
- Basic frame: acc_in=128'h1, acc_done pulse, out_ready=1 → bytes 01, then 00 ×15, then checksum 01. out_first only on byte 0, out_last only on byte 17. busy falls after the 17th transfer.
- Byte order: acc_in=128'h0F0E0D0C0B0A09080706050403020100, LSB_FIRST=1 → 00,01,…,0F, checksum 00. With LSB_FIRST=0 → 0F,…,00, checksum 00.
- Backpressure: out_ready toggled 1,0,0,1… with acc_in=128'hA5 → out_data/out_first/out_last stable during every stall. Sequence A5, 00 ×15, A5. No duplicated or lost byte.
- Overrun: acc_done again at byte 5 with a different acc_in → frame completes with the original data; overrun=1 until overrun_clr, then 0. Clear and set in the same cycle → stays 1.
- Back-to-back: second acc_done (acc_in=128'h2) in the same cycle as the checksum transfer → next cycle out_valid=1, out_first=1, out_data=02. overrun stays 0.
- Reset mid-frame: rst_n low at byte 8 → out_valid, busy and overrun are 0 asynchronously. After release, the block stays IDLE until the next acc_done, then runs a clean 17-byte frame.

Source files
------------

// File: rtl/aegis_pkg.sv
// Shared definitions for the accumulator result streamer and its byte selector.
package aegis_pkg;

  localparam int unsigned ACC_W_DEF       = 128;
  localparam int unsigned BYTE_W_DEF      = 8;
  localparam int unsigned BYTES_PER_FRAME = ACC_W_DEF / BYTE_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_CSUM   = 2'd2
  } state_t;

endpackage

// File: rtl/aegis_byte_mux.sv
// Combinational byte selector: picks byte idx out of a wide snapshot, in either byte order.
module aegis_byte_mux #(
  parameter int unsigned ACC_W     = 128,
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned IDX_W     = 4
) (
  input  logic [ACC_W-1:0]  snapshot,
  input  logic [IDX_W-1:0]  idx,
  output logic [BYTE_W-1:0] byte_out
);

  localparam int unsigned NBYTES = ACC_W / BYTE_W;

  always_comb begin
    int unsigned sel;
    sel = (LSB_FIRST != 0) ? 32'(idx) : (NBYTES - 1 - 32'(idx));
    byte_out = snapshot[sel*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/aegis_result_streamer.sv
// Snapshots the MAC accumulator on acc_done and streams it out as bytes plus an XOR checksum byte.
module aegis_result_streamer
  import aegis_pkg::*;
#(
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned BYTE_W    = BYTE_W_DEF,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              acc_done,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int unsigned NBYTES = ACC_W / BYTE_W;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [ACC_W-1:0]   snapshot;
  logic [BYTE_W-1:0]  csum;
  logic [BYTE_W-1:0]  mux_byte;
  logic               overrun_q;
  logic               capture;
  logic               xfer;
  logic               drop;

  aegis_byte_mux #(
    .ACC_W    (ACC_W),
    .BYTE_W   (BYTE_W),
    .LSB_FIRST(LSB_FIRST),
    .IDX_W    (IDX_W)
  ) u_byte_mux (
    .snapshot(snapshot),
    .idx     (idx),
    .byte_out(mux_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc_done) begin
          capture   = 1'b1;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        out_data  = mux_byte;
        out_first = (idx == '0);
        if (out_ready && (idx == LAST_IDX)) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        out_last  = 1'b1;
        // A new frame may start on the checksum transfer itself, avoiding an idle bubble.
        if (out_ready) begin
          if (acc_done) begin
            capture   = 1'b1;
            state_nxt = ST_STREAM;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign xfer    = out_valid && out_ready;
  assign drop    = acc_done && !capture;
  assign busy    = (state != ST_IDLE);
  assign overrun = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      snapshot  <= '0;
      csum      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (capture) begin
        snapshot <= acc_in;
        idx      <= '0;
        csum     <= '0;
      end else if (xfer && (state == ST_STREAM)) begin
        csum <= csum ^ mux_byte;
        // idx parks on the last byte while the checksum goes out; it restarts only on frame exit.
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end else if (xfer && (state == ST_CSUM)) begin
        idx <= '0;
      end

      if (drop)             overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aegis_result_streamer.sv
// Scoreboard bench: two streamers (LSB-first and MSB-first) share stimulus and are checked against a frame-level model.
module tb_aegis_result_streamer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] acc_in;
  logic         acc_done;
  logic         out_ready;
  logic         overrun_clr;

  logic [7:0] od [2];
  logic       ov [2];
  logic       of [2];
  logic       ol [2];
  logic       bz [2];
  logic       orun [2];

  always #5 clk = ~clk;

  aegis_result_streamer #(.ACC_W(128), .BYTE_W(8), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .acc_done(acc_done),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_first(of[0]), .out_last(ol[0]), .busy(bz[0]),
    .overrun(orun[0]), .overrun_clr(overrun_clr)
  );

  aegis_result_streamer #(.ACC_W(128), .BYTE_W(8), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .acc_done(acc_done),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_first(of[1]), .out_last(ol[1]), .busy(bz[1]),
    .overrun(orun[1]), .overrun_clr(overrun_clr)
  );

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       l;
  } exp_t;

  exp_t        exp_q [2][$];
  exp_t        e;
  int unsigned rem   = 0;
  logic        m_ovr = 1'b0;
  bit          m_xf, m_cap;
  int          checks = 0;
  int          passes = 0;
  int          mode   = 0;
  int unsigned pat    = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, d, act, exp, $time);
  endtask

  // Expected frame: 16 bytes in the chosen order, then XOR of all of them.
  function automatic void push_frame(input logic [127:0] a);
    for (int d = 0; d < 2; d++) begin
      logic [7:0] cs;
      logic [7:0] b;
      exp_t       x;
      cs = 8'h00;
      for (int k = 0; k < 16; k++) begin
        b = (d == 0) ? 8'(a >> (8*k)) : 8'(a >> (8*(15-k)));
        cs ^= b;
        x.d = b; x.f = (k == 0); x.l = 1'b0;
        exp_q[d].push_back(x);
      end
      x.d = cs; x.f = 1'b0; x.l = 1'b1;
      exp_q[d].push_back(x);
    end
  endfunction

  // Reference model: rem = bytes of the current frame still to be accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   = 0;
      m_ovr = 1'b0;
      exp_q[0].delete();
      exp_q[1].delete();
    end else begin
      m_xf  = (rem > 0) && out_ready;
      m_cap = acc_done && ((rem == 0) || ((rem == 1) && m_xf));
      if (m_xf) rem--;
      if (m_cap) begin
        rem = 17;
        push_frame(acc_in);
      end else if (acc_done) begin
        m_ovr = 1'b1;
      end else if (overrun_clr) begin
        m_ovr = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("valid", d, 32'(ov[d]), 32'(rem > 0));
      chk("busy", d, 32'(bz[d]), 32'(rem > 0));
      chk("overrun", d, 32'(orun[d]), 32'(m_ovr));
      if (ov[d] === 1'b1) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte dut%0d: got %0h with empty scoreboard", d, od[d]);
        end else begin
          e = exp_q[d][0];
          chk("data", d, 32'(od[d]), 32'(e.d));
          chk("first", d, 32'(of[d]), 32'(e.f));
          chk("last", d, 32'(ol[d]), 32'(e.l));
          if (out_ready) void'(exp_q[d].pop_front());
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: begin out_ready = ((pat % 3) == 0); pat++; end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [127:0] a);
    acc_in   = a;
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
  endtask

  task automatic wait_rem(input int unsigned n);
    for (int i = 0; i < 1000 && rem != n; i++) tick();
    if (rem != n) begin
      checks++;
      $display("FAIL wait_rem: remaining=%0d required %0d", rem, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; acc_in = '0; acc_done = 1'b0; overrun_clr = 1'b0; mode = 0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_data", d, 32'(od[d]), 32'h0);
      chk("rst_first", d, 32'(of[d]), 32'h0);
      chk("rst_last", d, 32'(ol[d]), 32'h0);
      chk("rst_valid", d, 32'(ov[d]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    pulse(128'h1);
    wait_rem(0);
    pulse(128'h0F0E0D0C0B0A09080706050403020100);
    wait_rem(0);

    mode = 1;
    pulse(128'hA5);
    wait_rem(0);
    mode = 0;
    tick();

    pulse(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    wait_rem(12);
    pulse(128'hDEAD_BEEF);
    wait_rem(0);
    repeat (2) tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    tick();
    pulse(128'h77);
    wait_rem(10);
    acc_done = 1'b1; overrun_clr = 1'b1; acc_in = 128'h99;
    tick();
    acc_done = 1'b0; overrun_clr = 1'b0;
    wait_rem(0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;

    pulse(128'h3C);
    wait_rem(1);
    acc_in = 128'h2; acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    wait_rem(0);
    tick();

    mode = 2;
    repeat (800) begin
      acc_in      = {$urandom(), $urandom(), $urandom(), $urandom()};
      acc_done    = ($urandom_range(0, 9) == 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    acc_done = 1'b0; overrun_clr = 1'b0;
    mode = 0;
    wait_rem(0);
    tick();

    pulse(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    wait_rem(14);
    pulse(128'h5555);
    wait_rem(9);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_valid", d, 32'(ov[d]), 32'h0);
      chk("async_busy", d, 32'(bz[d]), 32'h0);
      chk("async_overrun", d, 32'(orun[d]), 32'h0);
    end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    pulse(128'hCAFE_F00D);
    wait_rem(0);
    tick();

    for (int d = 0; d < 2; d++) chk("drain", d, 32'(exp_q[d].size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
